// File: rtl/mips_multicycle_controller.sv
// Main control unit of the multicycle MIPS core: Moore sequencer through
// fetch/decode/execute/memory/writeback plus the ALU function decoder.
module mips_multicycle_controller #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam state_t TRAP_STATE = ILLEGAL_TRAP ? S_HALT : S_FETCH;

    function automatic logic funct_ok(input logic [5:0] f);
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
            default:                               funct_ok = 1'b0;
        endcase
    endfunction

    function automatic logic instr_bad(input logic [5:0] op, input logic [5:0] f);
        case (op)
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: instr_bad = 1'b0;
            OP_RTYPE:                                    instr_bad = !funct_ok(f);
            default:                                     instr_bad = 1'b1;
        endcase
    endfunction

    state_t  state_r;
    state_t  state_next_s;
    state_t  dec_state_s;
    logic    is_bne_r;
    alu_op_t alu_op_s;
    logic    pc_write_s;
    logic    branch_s;
    logic    ir_write_s;
    logic    reg_write_s;
    logic    mem_write_s;
    logic    instr_done_s;
    logic    illegal_s;

    // State register; is_bne is captured once per instruction in DECODE
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_r  <= S_FETCH;
            is_bne_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_r == S_DECODE) begin
                is_bne_r <= (opcode == OP_BNE);
            end
        end
    end

    // Next-state sequencing
    always_comb begin
        state_next_s = S_FETCH;
        case (state_r)
            S_FETCH:  state_next_s = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   state_next_s = S_MEMADR;
                    OP_ADDI:        state_next_s = S_ADDIEXEC;
                    OP_RTYPE:       state_next_s = funct_ok(funct) ? S_EXECUTE : TRAP_STATE;
                    OP_BEQ, OP_BNE: state_next_s = S_BRANCH;
                    OP_J:           state_next_s = S_JUMP;
                    default:        state_next_s = TRAP_STATE;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_SW) begin
                    state_next_s = S_MEMWR;
                end else begin
                    state_next_s = S_MEMRD;
                end
            end
            S_MEMRD:    state_next_s = S_MEMWB;
            S_EXECUTE:  state_next_s = funct_ok(funct) ? S_ALUWB : TRAP_STATE;
            S_ADDIEXEC: state_next_s = S_ADDIWB;
            S_HALT:     state_next_s = S_HALT;
            default:    state_next_s = S_FETCH;
        endcase
    end

    // While in reset the outputs show FETCH with every enable held low
    assign dec_state_s = rstb ? state_r : S_FETCH;

    // Moore decode of the control word
    always_comb begin
        iord         = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        pc_src       = 2'b00;
        alu_op_s     = ALU_ADD;
        pc_write_s   = 1'b0;
        branch_s     = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        mem_write_s  = 1'b0;
        instr_done_s = 1'b0;
        illegal_s    = 1'b0;
        case (dec_state_s)
            S_FETCH: begin
                ir_write_s = 1'b1;
                alu_src_b  = 2'b01;
                pc_write_s = 1'b1;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                illegal_s = instr_bad(opcode, funct);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg   = 1'b1;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                mem_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op_s  = ALU_FUNCT;
                illegal_s = !funct_ok(funct);
            end
            S_ALUWB: begin
                reg_dst      = 1'b1;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_op_s     = ALU_SUB;
                branch_s     = 1'b1;
                pc_src       = 2'b01;
                instr_done_s = 1'b1;
            end
            S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_JUMP: begin
                pc_src       = 2'b10;
                pc_write_s   = 1'b1;
                instr_done_s = 1'b1;
            end
            default: begin
                iord = 1'b0;
            end
        endcase
    end

    // ALU function decode
    always_comb begin
        alu_control = 3'b010;
        case (alu_op_s)
            ALU_ADD: alu_control = 3'b010;
            ALU_SUB: alu_control = 3'b110;
            ALU_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = 3'b010;
                    FN_SUB:  alu_control = 3'b110;
                    FN_AND:  alu_control = 3'b000;
                    FN_OR:   alu_control = 3'b001;
                    FN_SLT:  alu_control = 3'b111;
                    default: alu_control = 3'b010;
                endcase
            end
            default: alu_control = 3'b010;
        endcase
    end

    assign pc_en      = rstb & (pc_write_s | (branch_s & (zero ^ is_bne_r)));
    assign ir_write   = rstb & ir_write_s;
    assign reg_write  = rstb & reg_write_s;
    assign mem_write  = rstb & mem_write_s;
    assign instr_done = rstb & instr_done_s;
    assign illegal    = rstb & illegal_s;

endmodule
